// File: rtl/master_bridge.sv
// master_bridge: single-outstanding CPU to AXI master bridge, one-beat 32-bit accesses
module master_bridge #(
    parameter logic [3:0] ID_VAL = 4'h0,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [3:0]        AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [31:0]       WDATA,
    output logic [3:0]        WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [3:0]        BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDAT  = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              aw_done, w_done;
    logic              accept, ar_hs, aw_hs, w_hs, r_last, b_hs;
    logic              unused_ids;

    // IDs are not checked; only one transaction is ever outstanding
    assign unused_ids = ^{RID, BID};

    assign accept = (state == IDLE) && cpu_req;
    assign ar_hs  = ARVALID && ARREADY;
    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign r_last = RREADY && RVALID && RLAST;
    assign b_hs   = BREADY && BVALID;

    // single-beat, 4-byte, INCR bursts; payload comes only from captured registers
    assign ARID    = ID_VAL;
    assign AWID    = ID_VAL;
    assign ARLEN   = 4'd0;
    assign AWLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign AWSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign AWBURST = 2'b01;
    assign ARADDR  = addr_q;
    assign AWADDR  = addr_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = WVALID;
    assign cpu_rdata = rdata_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state: write address and data channels complete independently
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cpu_req ? (cpu_we ? WADDR : RADDR) : IDLE;
            RADDR:   state_nx = ar_hs ? RDAT : RADDR;
            RDAT:    state_nx = r_last ? DONE : RDAT;
            WADDR:   state_nx = ((aw_done || aw_hs) && (w_done || w_hs)) ? WRESP : WADDR;
            WRESP:   state_nx = b_hs ? DONE : WRESP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from state and per-channel completion flags
    always_comb begin
        ARVALID  = state == RADDR;
        RREADY   = state == RDAT;
        AWVALID  = (state == WADDR) && !aw_done;
        WVALID   = (state == WADDR) && !w_done;
        BREADY   = state == WRESP;
        cpu_done = state == DONE;
        cpu_err  = (state == DONE) && err_q;
        cpu_busy = state != IDLE;
    end

    // request capture, handshake tracking, read data and error latching
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                wstrb_q <= cpu_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
            end
            if (r_last) begin
                rdata_q <= RDATA;
                err_q   <= RRESP != 2'b00;
            end
            if (b_hs) err_q <= BRESP != 2'b00;
        end
    end

endmodule
